conv_layer_sequencer: RTL

//  Sequences one 1-D convolution layer over a buffered input frame: steps output position and

---
 rtl/conv_seq_pkg.sv | 33 +++
 rtl/conv_layer_sequencer_wrap_counter.sv | 44 ++++
 rtl/conv_layer_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/conv_seq_pkg.sv
// Shared types and width helpers for the 1-D convolution layer sequencer.
// Imported by the sequencer top and its counter sub-module.
package conv_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_MAC   = 3'd2,
      S_EMIT  = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   function automatic int clog2_min1(input int v);
      int w;
      w = $clog2(v);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int data_w(input int input_size);
      return clog2_min1(input_size);
   endfunction

   function automatic int weight_w(input int num_kernels,
                                   input int kernel_size);
      return clog2_min1(num_kernels * kernel_size);
   endfunction

   function automatic int out_w(input int num_kernels,
                                input int out_len);
      return clog2_min1(num_kernels * out_len);
   endfunction

endpackage

// File: rtl/conv_layer_sequencer_wrap_counter.sv
// Modulo-MAX counter with synchronous clear and a terminal-count flag.
// Chained by wrap_o to build nested loop indices.
module wrap_counter
   import conv_seq_pkg::*;
#(
   parameter int MAX = 2,
   parameter int W   = clog2_min1(MAX)
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic         en_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o,
   output logic         wrap_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         at_max;

   assign at_max  = (count_q == W'(MAX - 1));
   assign count_o = count_q;
   assign wrap_o  = at_max;

   // Next count: clear wins, otherwise step and fold back at MAX-1.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = at_max ? '0 : count_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Loop sequencer for one 1-D convolution layer: kernel outer, position inner,
// taps innermost; drives RAM addresses, MAC control and the result handshake.
module conv_layer_sequencer
   import conv_seq_pkg::*;
#(
   parameter int INPUT_SIZE  = 64,
   parameter int KERNEL_SIZE = 8,
   parameter int NUM_KERNELS = 4,
   localparam int OUT_LEN    = INPUT_SIZE - KERNEL_SIZE + 1,
   localparam int DW         = data_w(INPUT_SIZE),
   localparam int WW         = weight_w(NUM_KERNELS, KERNEL_SIZE),
   localparam int OW         = out_w(NUM_KERNELS, OUT_LEN)
) (
   input  logic          clk_i,
   input  logic          reset_n_i,
   input  logic          start_i,
   input  logic          abort_i,
   input  logic          result_ready_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          mac_clear_o,
   output logic          mac_en_o,
   output logic [DW-1:0] data_addr_o,
   output logic [WW-1:0] weight_addr_o,
   output logic          result_valid_o,
   output logic [OW-1:0] out_addr_o
);

   localparam int TW = clog2_min1(KERNEL_SIZE);
   localparam int PW = clog2_min1(OUT_LEN);
   localparam int KW = clog2_min1(NUM_KERNELS);

   state_e state_q;
   state_e state_d;

   logic [TW-1:0] tap;
   logic [PW-1:0] pos;
   logic [KW-1:0] kernel;
   logic          tap_wrap;
   logic          pos_wrap;
   logic          kernel_wrap;

   logic cnt_clr;
   logic tap_en;
   logic pos_en;
   logic kernel_en;
   logic handshake;
   logic last_out;

   assign handshake = (state_q == S_EMIT) && result_ready_i;
   assign last_out  = pos_wrap && kernel_wrap;

   // Loop-counter control: idle/done/abort park all indices at zero.
   always_comb begin
      cnt_clr   = abort_i
                | (state_q == S_IDLE)
                | (state_q == S_DONE);
      tap_en    = (state_q == S_MAC);
      pos_en    = handshake;
      kernel_en = handshake && pos_wrap;
   end

   wrap_counter #(
      .MAX (KERNEL_SIZE),
      .W   (TW)
   ) u_tap (
      .clk_i   (clk_i),
      .rst_n_i (reset_n_i),
      .en_i    (tap_en),
      .clr_i   (cnt_clr),
      .count_o (tap),
      .wrap_o  (tap_wrap)
   );

   wrap_counter #(
      .MAX (OUT_LEN),
      .W   (PW)
   ) u_pos (
      .clk_i   (clk_i),
      .rst_n_i (reset_n_i),
      .en_i    (pos_en),
      .clr_i   (cnt_clr),
      .count_o (pos),
      .wrap_o  (pos_wrap)
   );

   wrap_counter #(
      .MAX (NUM_KERNELS),
      .W   (KW)
   ) u_kernel (
      .clk_i   (clk_i),
      .rst_n_i (reset_n_i),
      .en_i    (kernel_en),
      .clr_i   (cnt_clr),
      .count_o (kernel),
      .wrap_o  (kernel_wrap)
   );

   // Next-state logic; abort overrides every transition.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            state_d = S_MAC;
         end
         S_MAC: begin
            if (tap_wrap) state_d = S_EMIT;
         end
         S_EMIT: begin
            if (result_ready_i) begin
               state_d = last_out ? S_DONE : S_CLEAR;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (abort_i) state_d = S_IDLE;
   end

   // State register.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Moore control outputs decoded from the registered state.
   always_comb begin
      busy_o         = 1'b1;
      done_o         = 1'b0;
      mac_clear_o    = 1'b0;
      mac_en_o       = 1'b0;
      result_valid_o = 1'b0;
      unique case (1'b1)
         (state_q == S_IDLE):  busy_o         = 1'b0;
         (state_q == S_CLEAR): mac_clear_o    = 1'b1;
         (state_q == S_MAC):   mac_en_o       = 1'b1;
         (state_q == S_EMIT):  result_valid_o = 1'b1;
         (state_q == S_DONE):  done_o         = 1'b1;
         default:              busy_o         = 1'b0;
      endcase
   end

   // RAM and output addresses follow the loop indices directly.
   always_comb begin
      data_addr_o   = DW'(32'(pos) + 32'(tap));
      weight_addr_o = WW'(32'(kernel) * 32'(KERNEL_SIZE)
                        + 32'(tap));
      out_addr_o    = OW'(32'(kernel) * 32'(OUT_LEN)
                        + 32'(pos));
   end

endmodule
